// File: rtl/izh_ctrl_sequencer.sv
// Byte-stream configuration and run controller for the Izhikevich neuron core.
// Optional frame timeout: define IZH_FRAME_TIMEOUT_EN.
module izh_ctrl_sequencer #(
  parameter logic [7:0]  DIV_RESET      = 8'd0,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic [7:0]           cfg_data,
  output logic                 cfg_ready,
  input  logic [7:0]           stim_in,
  input  logic                 spike_in,
  output logic [7:0]           param_a,
  output logic [7:0]           param_b,
  output logic [7:0]           param_c,
  output logic [7:0]           param_d,
  output logic                 params_ready,
  output logic                 neuron_enable,
  output logic [7:0]           stimulus_out,
  output logic [CNT_WIDTH-1:0] spike_count,
  output logic                 running,
  output logic                 err
);

`ifdef IZH_FRAME_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, COMMIT} state_t;

  state_t            state;
  logic [2:0]        left;
  logic              is_div;
  logic              saved_ready;
  logic [31:0]       stage;
  logic [7:0]        divider;
  logic [7:0]        tick;
  logic [IDLE_W-1:0] idle_cnt;

  logic       xfer;
  logic [3:0] opcode;

  always_comb begin
    xfer   = cfg_valid & cfg_ready;
    opcode = cfg_data[7:4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      left          <= '0;
      is_div        <= 1'b0;
      saved_ready   <= 1'b0;
      stage         <= '0;
      divider       <= DIV_RESET;
      tick          <= '0;
      idle_cnt      <= '0;
      cfg_ready     <= 1'b1;
      param_a       <= '0;
      param_b       <= '0;
      param_c       <= '0;
      param_d       <= '0;
      params_ready  <= 1'b0;
      neuron_enable <= 1'b0;
      stimulus_out  <= '0;
      spike_count   <= '0;
      running       <= 1'b0;
      err           <= 1'b0;
    end else begin
      stimulus_out <= running ? stim_in : '0;

      if (xfer && state == IDLE && opcode == 4'h6)
        spike_count <= '0;
      else if (spike_in && running && spike_count != '1)
        spike_count <= spike_count + 1'b1;

      if (running && params_ready) begin
        if (tick == divider) begin
          neuron_enable <= 1'b1;
          tick          <= '0;
        end else begin
          neuron_enable <= 1'b0;
          tick          <= tick + 8'd1;
        end
      end else begin
        neuron_enable <= 1'b0;
      end

      // Command effects are applied after the tick update so RUN/HALT/SET_DIV clears win.
      case (state)
        IDLE: begin
          if (xfer) begin
            case (opcode)
              4'h1: begin
                state        <= PAYLOAD;
                left         <= 3'd4;
                is_div       <= 1'b0;
                idle_cnt     <= '0;
                saved_ready  <= params_ready;
                params_ready <= 1'b0;
              end
              4'h2: begin
                params_ready <= 1'b1;
                case (cfg_data[1:0])
                  2'd0: begin param_a <= 8'd2;  param_b <= 8'd20; param_c <= 8'd133; param_d <= 8'd8; end
                  2'd1: begin param_a <= 8'd2;  param_b <= 8'd20; param_c <= 8'd143; param_d <= 8'd4; end
                  2'd2: begin param_a <= 8'd2;  param_b <= 8'd20; param_c <= 8'd148; param_d <= 8'd2; end
                  default: begin param_a <= 8'd10; param_b <= 8'd20; param_c <= 8'd133; param_d <= 8'd2; end
                endcase
              end
              4'h3: begin
                state    <= PAYLOAD;
                left     <= 3'd1;
                is_div   <= 1'b1;
                idle_cnt <= '0;
              end
              4'h4: begin
                if (params_ready) begin
                  running <= 1'b1;
                  tick    <= '0;
                end else begin
                  err <= 1'b1;
                end
              end
              4'h5: begin
                running <= 1'b0;
                tick    <= '0;
              end
              4'h6: ;
              default: err <= 1'b1;
            endcase
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            stage    <= {stage[23:0], cfg_data};
            left     <= left - 3'd1;
            idle_cnt <= '0;
            if (left == 3'd1) begin
              state     <= COMMIT;
              cfg_ready <= 1'b0;
            end
          end else if (TIMEOUT_EN) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              state    <= IDLE;
              idle_cnt <= '0;
              err      <= 1'b1;
              if (!is_div) params_ready <= saved_ready;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          if (is_div) begin
            divider <= stage[7:0];
            tick    <= '0;
          end else begin
            param_a      <= stage[31:24];
            param_b      <= stage[23:16];
            param_c      <= stage[15:8];
            param_d      <= stage[7:0];
            params_ready <= 1'b1;
          end
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/izh_ctrl_sequencer.md
Name: izh_ctrl_sequencer

Overview:
- Byte-stream configuration and run controller for the Izhikevich neuron datapath.
- Decodes command frames into param_a..param_d and params_ready, and commits parameter sets atomically.
- Generates the divided neuron_enable timestep strobe, gates stimulus, and counts output spikes.
- Sits between the host byte interface (SPI/uio deserialiser) and the neuron core.

Parameters:
- DIV_RESET, 0, timestep divider value loaded at reset.
- CNT_WIDTH, 8, spike counter width.
- TIMEOUT_CYCLES, 255, idle-cycle limit inside a partial frame (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  host byte valid.
- cfg_data  in  8  host byte.
- cfg_ready  out  1  controller accepts byte; a transfer occurs when cfg_valid and cfg_ready are both 1.
- stim_in  in  8  raw stimulus.
- spike_in  in  1  neuron spike_out.
- param_a, param_b, param_c, param_d  out  8 each  committed neuron parameters.
- params_ready  out  1  parameter set valid.
- neuron_enable  out  1  one-cycle timestep strobe.
- stimulus_out  out  8  gated stimulus to neuron.
- spike_count  out  CNT_WIDTH  saturating spike count.
- running  out  1  run state.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values (all outputs):
  - params, spike_count, stimulus_out = 0.
  - params_ready, neuron_enable, running, err = 0.
  - cfg_ready = 1 from the first cycle after reset.
  - divider = DIV_RESET; FSM = IDLE.
- Frame format: header byte; opcode = cfg_data[7:4], arg = cfg_data[1:0].
  - 0x1 WRITE_PARAMS: 4 payload bytes, in order a, b, c, d.
  - 0x2 PRESET: no payload; arg selects the set:
    - 0 = RS: a=2, b=20, c=133, d=8.
    - 1 = IB: a=2, b=20, c=143, d=4.
    - 2 = CH: a=2, b=20, c=148, d=2.
    - 3 = FS: a=10, b=20, c=133, d=2.
  - 0x3 SET_DIV: 1 payload byte = divider.
  - 0x4 RUN. 0x5 HALT. 0x6 CLR_CNT.
  - Any other opcode: err <= 1, frame discarded.
- FSM states: IDLE, PAYLOAD, COMMIT.
  - IDLE -> PAYLOAD on a WRITE_PARAMS or SET_DIV header.
  - Single-byte commands execute the cycle after acceptance and stay in IDLE.
  - PAYLOAD counts the remaining bytes (4 or 1); after the last byte -> COMMIT.
  - COMMIT lasts one cycle with cfg_ready = 0, copies staging registers to the outputs, then -> IDLE.
  - cfg_ready = 1 in IDLE and PAYLOAD.
- WRITE_PARAMS:
  - params_ready drops the cycle after header acceptance.
  - Payload goes to staging registers; param outputs do not change mid-frame.
  - On COMMIT, param outputs update and params_ready = 1 on the next cycle.
- PRESET: param outputs updated and params_ready = 1 one cycle after acceptance.
- RUN:
  - If params_ready = 1: running <= 1 and the tick counter clears.
  - Otherwise: err <= 1 and running stays 0.
- HALT: running <= 0; tick counter clears.
- Timestep strobe:
  - While running and params_ready, the tick counter counts 0..divider.
  - neuron_enable = 1 for exactly the cycle the counter equals divider, then the counter wraps to 0.
  - divider = 0 gives an enable every cycle; divider = N gives a period of N+1.
  - When params_ready = 0 or running = 0: counter holds and neuron_enable = 0.
  - SET_DIV during run takes effect at COMMIT, and the counter clears.
- stimulus_out: registered from stim_in every cycle while running; 0 when not running (1-cycle latency).
- spike_count:
  - Increments on each cycle with spike_in = 1 and running = 1.
  - Saturates at all-ones.
  - CLR_CNT and a spike in the same cycle give 0 (clear wins).
- err: sticky; cleared only by reset.
- Reset asserted mid-frame: the partial frame is dropped and all state returns to its reset values.

Optional Feature:
- Macro: IZH_FRAME_TIMEOUT_EN.
- Defined:
  - In PAYLOAD, an idle counter increments each cycle without a transfer and clears on each transfer.
  - On reaching TIMEOUT_CYCLES: frame aborted, FSM -> IDLE, staging discarded, err <= 1.
  - params_ready is restored to its pre-frame value for WRITE_PARAMS.
- Undefined: PAYLOAD waits indefinitely.

Test Plan:
- Reset, then bytes 0x10,0x02,0x14,0x85,0x08:
  - params_ready is low from the cycle after 0x10 until COMMIT.
  - Then a=2, b=20, c=133, d=8 and params_ready = 1.
  - cfg_ready is low for exactly 1 cycle.
- 0x23 then 0x40:
  - params = 10/20/133/2, running = 1.
  - neuron_enable every cycle (divider 0); stimulus_out follows stim_in delayed 1 cycle.
- 0x30,0x03 while running: neuron_enable pulses once every 4 cycles; 0x50 gives running = 0 and enable stays low.
- From reset, 0x40 with no params: err = 1, running = 0; a following 0x70 also leaves err = 1.
- Run with spike_in held high for 300 cycles: spike_count saturates at 255.
  - 0x60 coincident with a spike gives count 0.
- (IZH_FRAME_TIMEOUT_EN) 0x10,0x05 then 255 idle cycles:
  - FSM returns to IDLE, err = 1, params are unchanged.
  - params_ready is restored to its pre-frame value.
